pipe_hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. It is the producer of the `stall`/`flush` controls that every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB) consumes. It resolves three hazards:
- variable-latency data-memory accesses (req/ack handshake with a watchdog),
- load-use dependencies,
- taken branches.

It also exports a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the 5-stage MIPS core.
// Produces the stall/flush controls consumed by IF_ID, ID_EX, EX_MEM and MEM_WB.
// It resolves three kinds of hazard, in priority order:
//   1. variable-latency data memory (req/ack handshake, guarded by a watchdog),
//   2. load-use dependencies,
//   3. taken branches.
// It also keeps a saturating count of stall cycles for performance monitoring.
//
// Ports:
//   clk, rst                   clock (rising edge) and synchronous active-high reset
//   ID_rs, ID_rt               source registers of the instruction in ID
//   ID_use_rs, ID_use_rt       the ID instruction actually reads rs / rt
//   ID_branch_taken            branch/jump resolved taken in ID
//   EX_memtoreg, EX_regwrite   the EX instruction is a load / writes the register file
//   EX_wraddr                  destination register of the EX instruction
//   MEM_memreq, mem_ack        data-memory request from MEM, and its completion
//   stall_if/id/ex/mem         hold the respective pipeline register
//   flush_id/ex/wb             load a NOP into IF_ID / ID_EX / MEM_WB
//   bus_err                    memory watchdog expired; sticky until reset
//   stall_cycles               saturating count of cycles with stall_if high
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_use_rs,
    input  logic              ID_use_rt,
    input  logic              ID_branch_taken,
    input  logic              EX_memtoreg,
    input  logic              EX_regwrite,
    input  logic [REG_AW-1:0] EX_wraddr,
    input  logic              MEM_memreq,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_wb,
    output logic              bus_err,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    localparam logic [7:0]       TimeoutW = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             load_use;
    logic             mem_stall;

    // Writes to register 0 are discarded by the register file, so they never create a hazard.
    assign load_use = EX_memtoreg && EX_regwrite && (EX_wraddr != '0) &&
                      ((ID_use_rs && (EX_wraddr == ID_rs)) ||
                       (ID_use_rt && (EX_wraddr == ID_rt)));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        flush_wb   = 1'b0;
        bus_err    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (MEM_memreq && !mem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else if (load_use) begin
                    // One bubble: hold IF/ID, let EX take a NOP while EX and MEM advance.
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end else if (ID_branch_taken) begin
                    flush_id = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    // Ack wins even on the timeout cycle; all controls drop so MEM_WB captures.
                    state_d    = StRun;
                    wait_cnt_d = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q >= TimeoutW) begin
                        state_d = StErr;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            StErr: begin
                mem_stall = 1'b1;
                bus_err   = 1'b1;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = 8'd0;
            end
        endcase

        if (mem_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end

        // During reset the pipeline is filled with NOPs and allowed to advance.
        if (rst) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            stall_ex  = 1'b0;
            stall_mem = 1'b0;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_wb  = 1'b1;
            bus_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            wait_cnt_q   <= 8'd0;
            stall_cycles <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (stall_if && (stall_cycles != CntMax)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4). Each step pushes the expected
// controls onto a scoreboard queue; they are popped and compared on the falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_wraddr;
    logic       ID_use_rs, ID_use_rt, ID_branch_taken;
    logic       EX_memtoreg, EX_regwrite, MEM_memreq, mem_ack;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, bus_err;
    logic [3:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_cnt;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] fl;
        logic       be;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    pipe_hazard_ctrl #(
        .REG_AW (5),
        .TIMEOUT(4),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_use_rs      (ID_use_rs),
        .ID_use_rt      (ID_use_rt),
        .ID_branch_taken(ID_branch_taken),
        .EX_memtoreg    (EX_memtoreg),
        .EX_regwrite    (EX_regwrite),
        .EX_wraddr      (EX_wraddr),
        .MEM_memreq     (MEM_memreq),
        .mem_ack        (mem_ack),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .flush_wb       (flush_wb),
        .bus_err        (bus_err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        ID_rs = '0; ID_rt = '0; EX_wraddr = '0;
        ID_use_rs = 1'b0; ID_use_rt = 1'b0; ID_branch_taken = 1'b0;
        EX_memtoreg = 1'b0; EX_regwrite = 1'b0; MEM_memreq = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt);
        EX_memtoreg = 1'b1; EX_regwrite = 1'b1; EX_wraddr = wr;
        ID_rs = rs; ID_use_rs = urs; ID_rt = rt; ID_use_rt = urt;
    endtask

    // st = {if,id,ex,mem}, fl = {id,ex,wb}. Called just after a rising edge with inputs set.
    task automatic cycle(input string tag, input logic [3:0] st, input logic [2:0] fl,
                         input logic be);
        exp_t e;
        logic [3:0] obs_st;
        logic [2:0] obs_fl;
        e.st = st; e.fl = fl; e.be = be; e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        obs_st = {stall_if, stall_id, stall_ex, stall_mem};
        obs_fl = {flush_id, flush_ex, flush_wb};
        checks++;
        assert (obs_st === e.st) else begin
            errors++;
            $error("FAIL %s stalls got %b want %b", tag, obs_st, e.st);
        end
        checks++;
        assert (obs_fl === e.fl) else begin
            errors++;
            $error("FAIL %s flushes got %b want %b", tag, obs_fl, e.fl);
        end
        checks++;
        assert (bus_err === e.be) else begin
            errors++;
            $error("FAIL %s bus_err got %b want %b", tag, bus_err, e.be);
        end
        checks++;
        assert (stall_cycles === e.cnt) else begin
            errors++;
            $error("FAIL %s stall_cycles got %0d want %0d", tag, stall_cycles, e.cnt);
        end
        // Counter model for the coming edge.
        if (rst) exp_cnt = 4'd0;
        else if (e.st[3] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 4'd0;

        cycle("reset", 4'b0000, 3'b111, 1'b0);
        rst = 1'b0;
        cycle("idle", 4'b0000, 3'b000, 1'b0);

        // Load-use on rs: one bubble, then EX holds the bubble.
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        cycle("lu_rs", 4'b1100, 3'b010, 1'b0);
        clear_in();
        cycle("lu_after", 4'b0000, 3'b000, 1'b0);
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        cycle("lu_r0", 4'b0000, 3'b000, 1'b0);
        set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
        cycle("lu_rt", 4'b1100, 3'b010, 1'b0);
        set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b0);
        cycle("lu_rt_unused", 4'b0000, 3'b000, 1'b0);
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        EX_regwrite = 1'b0;
        cycle("lu_nowrite", 4'b0000, 3'b000, 1'b0);
        clear_in();

        // Memory wait with ack 3 cycles after the request.
        MEM_memreq = 1'b1;
        cycle("mw_req", 4'b1111, 3'b001, 1'b0);
        cycle("mw_w1", 4'b1111, 3'b001, 1'b0);
        cycle("mw_w2", 4'b1111, 3'b001, 1'b0);
        mem_ack = 1'b1;
        cycle("mw_ack", 4'b0000, 3'b000, 1'b0);
        clear_in();
        cycle("mw_done", 4'b0000, 3'b000, 1'b0);

        // Same-cycle ack, then a stray ack in RUN.
        MEM_memreq = 1'b1; mem_ack = 1'b1;
        cycle("mw_same", 4'b0000, 3'b000, 1'b0);
        MEM_memreq = 1'b0;
        cycle("stray_ack", 4'b0000, 3'b000, 1'b0);
        clear_in();

        // Priority: memory > load-use > branch.
        set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
        ID_branch_taken = 1'b1; MEM_memreq = 1'b1;
        cycle("pri_mem", 4'b1111, 3'b001, 1'b0);
        mem_ack = 1'b1;
        cycle("pri_ack", 4'b0000, 3'b000, 1'b0);
        MEM_memreq = 1'b0; mem_ack = 1'b0;
        cycle("pri_lu", 4'b1100, 3'b010, 1'b0);
        EX_memtoreg = 1'b0; EX_regwrite = 1'b0;
        cycle("pri_br", 4'b0000, 3'b100, 1'b0);
        clear_in();

        // Reset in MEM_WAIT at wait_cnt = 2.
        MEM_memreq = 1'b1;
        cycle("rst_req", 4'b1111, 3'b001, 1'b0);
        cycle("rst_w1", 4'b1111, 3'b001, 1'b0);
        rst = 1'b1;
        cycle("rst_mid", 4'b0000, 3'b111, 1'b0);
        rst = 1'b0; MEM_memreq = 1'b0;
        cycle("rst_run", 4'b0000, 3'b000, 1'b0);

        // Ack on the timeout cycle wins.
        MEM_memreq = 1'b1;
        cycle("to_req", 4'b1111, 3'b001, 1'b0);
        for (int i = 1; i < 4; i++) cycle("to_wait", 4'b1111, 3'b001, 1'b0);
        mem_ack = 1'b1;
        cycle("to_ack", 4'b0000, 3'b000, 1'b0);
        clear_in();
        cycle("to_run", 4'b0000, 3'b000, 1'b0);

        // Watchdog: no ack, ERR after wait_cnt reaches 4; counter saturates.
        MEM_memreq = 1'b1;
        cycle("wd_req", 4'b1111, 3'b001, 1'b0);
        for (int i = 1; i <= 4; i++) cycle("wd_wait", 4'b1111, 3'b001, 1'b0);
        MEM_memreq = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) cycle("wd_err", 4'b1111, 3'b001, 1'b1);
        checks++;
        assert (stall_cycles === 4'd15) else begin
            errors++;
            $error("FAIL sat stall_cycles got %0d want 15", stall_cycles);
        end
        mem_ack = 1'b0;
        rst = 1'b1;
        cycle("wd_rst", 4'b0000, 3'b111, 1'b0);
        rst = 1'b0;
        cycle("wd_clear", 4'b0000, 3'b000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
